sobel_gradient: RTL
===================

Name: sobel_gradient

Overview:
- Streaming 3x3 Sobel stage directly upstream of the stroke generator. It consumes a raster-order grayscale reference image and produces per-pixel signed gradients gx and gy plus a magnitude.
- The stroke generator uses these values to orient and terminate strokes.
- Produces exactly one output per input pixel, in raster order. An end-of-frame flush drains the pipeline.

Parameters:
- IMG_W, 64, image width in pixels (>=4)
- IMG_H, 48, image height in pixels (>=3)
- PIX_W, 8, pixel bit width; gradient width GRAD_W = PIX_W+3

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  input pixel valid
- i_pix  in  PIX_W  unsigned pixel, raster order
- o_ready  out  1  high when input is accepted; a pixel is accepted when i_valid&&o_ready
- o_valid  out  1  output sample valid (single-cycle per sample)
- o_gx  out  GRAD_W  signed horizontal gradient
- o_gy  out  GRAD_W  signed vertical gradient
- o_mag  out  PIX_W  (|gx|+|gy|)>>3
- o_x  out  $clog2(IMG_W)  column of output sample
- o_y  out  $clog2(IMG_H)  row of output sample
- o_eof  out  1  high with the last sample of a frame (N-1, N=IMG_W*IMG_H)

Behaviour:
- Reset values:
  - o_ready=1.
  - o_valid=0, o_eof=0.
  - o_gx, o_gy, o_mag, o_x and o_y are all 0.
  - State=IDLE; all counters 0.
  - Line-buffer contents are undefined; no output ever depends on stale data.
- Reset mid-frame: all partial-frame state is discarded. The next accepted pixel is (0,0) of a new frame.
- Accepted pixels are indexed k=0..N-1. There is no input backpressure other than o_ready. Pixels offered while o_ready=0 are dropped and not counted.
- Output sample k is emitted (registered, o_valid=1) on the cycle after pixel k+IMG_W+1 is accepted, when k+IMG_W+1 < N. Gaps in i_valid create equal gaps in o_valid.
- States:
  - IDLE: no pixel of the current frame accepted yet; o_ready=1. Accepting a pixel goes to FILL.
  - FILL: fewer than IMG_W+1 pixels accepted; no outputs. Accepting pixel IMG_W goes to RUN.
  - RUN: one output per accepted pixel. Accepting pixel N-1 goes to FLUSH.
  - FLUSH: o_ready=0. Outputs N-IMG_W-1 .. N-1 are emitted on consecutive cycles regardless of i_valid. The cycle after the last output (o_eof=1), the state returns to IDLE with o_ready=1.
- FLUSH timing: if pixel N-1 is accepted at cycle t, then:
  - output N-IMG_W-2 appears at t+1;
  - flush outputs appear at t+2 .. t+IMG_W+2;
  - o_ready is low from t+1 through t+IMG_W+2.
- Window and arithmetic:
  - The window is formed from two IMG_W-deep line buffers plus 3x3 shift registers.
  - gx = (p[-1][+1]+2p[0][+1]+p[+1][+1]) - (p[-1][-1]+2p[0][-1]+p[+1][-1]), where the first index is row offset and the second is column offset.
  - gy = (bottom row weighted 1,2,1) - (top row weighted 1,2,1).
  - Both are signed GRAD_W; range ±4*(2^PIX_W-1) fits with no overflow.
  - Absolute value is two's-complement negation when the sign bit is set.
  - o_mag = (|gx|+|gy|)>>3, max 2040>>3=255; no saturation is needed.
- Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) output gx=gy=mag=0 with o_valid still asserted. This guarantees that no wrap-around neighbour from another row or frame is ever used.
- o_x/o_y track the output sample index; they wrap at IMG_W and at IMG_H.
- Back-to-back frames: a pixel may be accepted on the first IDLE cycle after FLUSH.

Decomposition:
- Package stroke_pkg holds:
  - PIX_W and GRAD_W localparams;
  - typedef pix_t (logic [PIX_W-1:0]) and grad_t (logic signed [GRAD_W-1:0]);
  - enum sobel_state_t {IDLE, FILL, RUN, FLUSH}.
  - The stroke generator imports the same grad_t.
- One sub-module, sobel_line_buffer:
  - IMG_W-deep, PIX_W-wide delay line with enable and a circular pointer.
  - Instantiated twice.

Test Plan:
- Configuration for all scenarios: IMG_W=8, IMG_H=6 (N=48).
- Constant image: all pixels 100 -> 48 outputs, all gx=gy=mag=0; o_eof only on sample 47 (x=7, y=5).
- Horizontal ramp: pix=4*x -> interior gx=+32, gy=0, mag=4; borders all 0.
- Vertical step: rows 0-2=0, rows 3-5=200:
  - rows 2 and 3, interior x -> gx=0, gy=+800, mag=100;
  - all other samples 0.
- Continuous input, flush timing: pixel 47 accepted at t -> sample 38 at t+1, samples 39..47 at t+2..t+10, o_ready=0 over t+1..t+10; pixel offered at t+5 is dropped.
- Random i_valid gaps with the ramp image -> identical sample sequence to the gapless run; exactly 48 o_valid pulses.
- rst pulsed after 20 pixels, then a full constant-50 frame -> no outputs before the new frame's pixel 9; 48 correct zero outputs; a second frame back-to-back after IDLE is accepted immediately.

Source files
------------

// File: rtl/stroke_pkg.sv
// Shared types for the stroke pipeline: pixel/gradient types and the Sobel
// stage state encoding.
package stroke_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = PIX_W + 3;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} sobel_state_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// DEPTH-deep delay line: while en is high, dout is the value written DEPTH
// enables ago, and din takes its slot.
module sobel_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  // Read-before-write on the same slot gives exactly DEPTH enables of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end
endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel stage: one registered gx/gy/magnitude sample per input
// pixel in raster order, with an end-of-frame flush of the last IMG_W+1 samples.
module sobel_gradient #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int PIX_W = 8,
  localparam int GRAD_W = PIX_W + 3,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [PIX_W-1:0]         i_pix,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic signed [GRAD_W-1:0] o_gx,
  output logic signed [GRAD_W-1:0] o_gy,
  output logic [PIX_W-1:0]         o_mag,
  output logic [XW-1:0]            o_x,
  output logic [YW-1:0]            o_y,
  output logic                     o_eof
);
  import stroke_pkg::sobel_state_t;
  import stroke_pkg::IDLE;
  import stroke_pkg::FILL;
  import stroke_pkg::RUN;
  import stroke_pkg::FLUSH;

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(N);
  localparam int FW = $clog2(IMG_W + 2);

  sobel_state_t     state;
  logic [CW-1:0]    in_cnt;
  logic [FW-1:0]    fcnt;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic [PIX_W-1:0] mid, top, b0, b1, m0, m1, t0, t1;
  logic             accept, emit, border, last;
  logic [GRAD_W-1:0] right_sum, left_sum, bot_sum, top_sum;
  logic [GRAD_W-1:0] gx_u, gy_u, gx_abs, gy_abs;
  logic [GRAD_W:0]   mag_sum;

  // Handshake: a pixel transfers on a rising edge where i_valid && o_ready;
  // there is no other backpressure and offers while o_ready=0 are dropped.
  assign accept = i_valid && o_ready;
  assign emit   = (state == RUN && accept) || (state == FLUSH && fcnt <= FW'(IMG_W));
  assign border = (out_x == '0) || (out_x == XW'(IMG_W - 1)) ||
                  (out_y == '0) || (out_y == YW'(IMG_H - 1));
  assign last   = (out_x == XW'(IMG_W - 1)) && (out_y == YW'(IMG_H - 1));

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
    .clk (clk), .rst (rst), .en (accept), .din (i_pix), .dout (mid)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
    .clk (clk), .rst (rst), .en (accept), .din (mid), .dout (top)
  );

  // Window centred one row and one column behind the incoming pixel:
  // column +1 is (top, mid, i_pix), column 0 is (t0, m0, b0), column -1 is (t1, m1, b1).
  assign right_sum = {3'b0, top} + {2'b0, mid, 1'b0} + {3'b0, i_pix};
  assign left_sum  = {3'b0, t1}  + {2'b0, m1, 1'b0}  + {3'b0, b1};
  assign bot_sum   = {3'b0, b1}  + {2'b0, b0, 1'b0}  + {3'b0, i_pix};
  assign top_sum   = {3'b0, t1}  + {2'b0, t0, 1'b0}  + {3'b0, top};
  assign gx_u      = right_sum - left_sum;
  assign gy_u      = bot_sum - top_sum;
  assign gx_abs    = gx_u[GRAD_W-1] ? -gx_u : gx_u;
  assign gy_abs    = gy_u[GRAD_W-1] ? -gy_u : gy_u;
  assign mag_sum   = {1'b0, gx_abs} + {1'b0, gy_abs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      o_gx    <= '0;
      o_gy    <= '0;
      o_mag   <= '0;
      o_x     <= '0;
      o_y     <= '0;
      in_cnt  <= '0;
      fcnt    <= '0;
      out_x   <= '0;
      out_y   <= '0;
      b0 <= '0; b1 <= '0; m0 <= '0; m1 <= '0; t0 <= '0; t1 <= '0;
    end else begin
      o_valid <= 1'b0;
      o_eof   <= 1'b0;

      if (accept) begin
        b0 <= i_pix; b1 <= b0;
        m0 <= mid;   m1 <= m0;
        t0 <= top;   t1 <= t0;
        in_cnt <= (in_cnt == CW'(N - 1)) ? '0 : in_cnt + 1'b1;
      end

      // Border samples are forced to zero so wrapped neighbours never leak out.
      if (emit) begin
        o_valid <= 1'b1;
        o_eof   <= last;
        o_x     <= out_x;
        o_y     <= out_y;
        o_gx    <= border ? '0 : signed'(gx_u);
        o_gy    <= border ? '0 : signed'(gy_u);
        o_mag   <= border ? '0 : PIX_W'(mag_sum >> 3);
        if (out_x == XW'(IMG_W - 1)) begin
          out_x <= '0;
          out_y <= (out_y == YW'(IMG_H - 1)) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end

      case (state)
        IDLE: if (accept) state <= FILL;
        FILL: if (accept && in_cnt == CW'(IMG_W)) state <= RUN;
        RUN: begin
          if (accept && in_cnt == CW'(N - 1)) begin
            state   <= FLUSH;
            o_ready <= 1'b0;
            fcnt    <= '0;
          end
        end
        FLUSH: begin
          // One idle cycle after the eof sample before accepting the next frame.
          fcnt <= fcnt + 1'b1;
          if (fcnt == FW'(IMG_W + 1)) begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
